crypto_core_arbiter: RTL and testbench
======================================

Name: crypto_core_arbiter

Overview:
Shares one block-cipher core (AES-128/DES/TDEA wrapper, start/done interface) between NUM_REQ requesters. Round-robin grant, latching of key/data/direction, sequencing of the core, and routing of the result back to the requester that issued it. Skips key re-expansion when the key matches the one last loaded. A watchdog recovers from a hung core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BLOCK_W, 128, data block width (64 for DES/TDEA builds)
KEY_W, 128, key width (up to 192 for TDEA)
TIMEOUT, 1024, max cycles in WAIT before abort (>= core worst-case latency + 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_key  in  NUM_REQ x KEY_W  per-requester key
req_data  in  NUM_REQ x BLOCK_W  per-requester input block
req_dec  in  NUM_REQ  1 = decrypt, 0 = encrypt
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_id  out  $clog2(NUM_REQ)  index of requester owning the result
rsp_data  out  BLOCK_W  result block
rsp_err  out  1  1 = watchdog abort; rsp_data is zero
core_start  out  1  one-cycle start pulse
core_key_load  out  1  qualifies core_start: expand core_key first
core_key  out  KEY_W  key to core; stable from ISSUE to done
core_din  out  BLOCK_W  block to core; stable from ISSUE to done
core_dec  out  1  direction to core
core_abort  out  1  one-cycle core reset pulse on timeout
core_done  in  1  one-cycle completion pulse
core_dout  in  BLOCK_W  core result, valid with core_done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0; rsp_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - key_cached_valid=0; watchdog=0.
- IDLE:
  - If any req_valid, grant g = first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; transfer completes that cycle.
  - Latch key, data, dec and g; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
- ISSUE (exactly 1 cycle):
  - Assert core_start=1.
  - core_key_load=1 iff !key_cached_valid or latched key != cached key.
  - When core_key_load=1: update cached key and set key_cached_valid=1.
  - Clear watchdog; go to WAIT.
  - Accept-to-core_start latency is 1 cycle.
- WAIT:
  - Watchdog increments each cycle.
  - core_done: latch core_dout; rsp_err=0; go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: core_abort=1 for 1 cycle; rsp_data=0; rsp_err=1; key_cached_valid=0; go to RESP.
  - core_done in the same cycle as the timeout: done wins and no abort is issued.
  - core_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id=g; rsp_data and rsp_err held stable until rsp_ready.
  - rsp_valid && rsp_ready: last_grant=g; go to IDLE; rsp_valid=0 next cycle.
  - No new grant in the handshake cycle, so minimum request-to-request spacing is accept+1+latency+2 cycles.
- Requests:
  - req_valid may be withdrawn at any time while not granted.
  - A granted requester is not re-granted until all other pending requesters have been served.
- Outputs: all registered except req_ready.
- Reset mid-operation: immediately return to the reset state; any in-flight result is dropped, and the core must be reset from the same rst_n.

Decomposition:
- Package crypto_arb_pkg:
  - state enum arb_state_e {IDLE, ISSUE, WAIT, RESP}
  - default widths BLOCK_W_AES=128, BLOCK_W_DES=64, KEY_W_AES=128, KEY_W_TDEA=192
  - function idx_w(n) for id width
- Sub-module rr_arbiter:
  - inputs: req vector, last_grant
  - outputs: one-hot grant and encoded index
  - purely combinational, reusable by the hash-core scheduler.

Test Plan:
- Single request, cold key:
  - stimulus: req0 with key 000102…0f, pt 00112233445566778899aabbccddeeff, core model latency 10.
  - required: core_start and core_key_load 1 cycle after accept; rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_err 0.
- Key reuse:
  - stimulus: second req0 with the same key, pt 00…00.
  - required: core_key_load=0 at core_start; correct ciphertext returned.
  - stimulus: a third request with a different key.
  - required: core_key_load=1.
- Round-robin fairness:
  - stimulus: req_valid=4'b1111 held for 8 transactions.
  - required: rsp_id sequence 0,1,2,3,0,1,2,3; req_ready always one-hot.
- Backpressure:
  - stimulus: rsp_ready held 0 for 20 cycles in RESP.
  - required: rsp_valid, rsp_id and rsp_data stable; no req_ready asserted; IDLE entered 1 cycle after rsp_ready.
- Watchdog:
  - stimulus: core model never raises done, TIMEOUT=16.
  - required: core_abort pulse in the 16th WAIT cycle; rsp_err=1, rsp_data=0; next request has core_key_load=1.
  - stimulus: done in the same cycle as the timeout.
  - required: normal response, no abort.
- Reset mid-WAIT:
  - stimulus: rst_n low for 2 cycles during WAIT.
  - required: all outputs 0 asynchronously; after release req0 wins first; a late core_done is ignored.

Source files
------------

// File: rtl/crypto_core_arbiter_pkg.sv
// Shared types and widths for the crypto core arbiter and its round-robin helper.
package crypto_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   localparam int BLOCK_W_AES = 128;
   localparam int BLOCK_W_DES = 64;
   localparam int KEY_W_AES   = 128;
   localparam int KEY_W_TDEA  = 192;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/crypto_core_arbiter_if.sv
// Requester, response and cipher-core signals of the arbiter bundled into one interface.
interface crypto_core_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int BLOCK_W = 128,
   parameter int KEY_W   = 128
);
   import crypto_arb_pkg::*;

   localparam int ID_W = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0][KEY_W-1:0]   req_key;
   logic [NUM_REQ-1:0][BLOCK_W-1:0] req_data;
   logic [NUM_REQ-1:0]              req_dec;

   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [ID_W-1:0]                 rsp_id;
   logic [BLOCK_W-1:0]              rsp_data;
   logic                            rsp_err;

   logic                            core_start;
   logic                            core_key_load;
   logic [KEY_W-1:0]                core_key;
   logic [BLOCK_W-1:0]              core_din;
   logic                            core_dec;
   logic                            core_abort;
   logic                            core_done;
   logic [BLOCK_W-1:0]              core_dout;

   // The arbiter is the slave; requesters plus the core sit on the master side.
   modport slave (
      input  req_valid, req_key, req_data, req_dec, rsp_ready, core_done, core_dout,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             core_start, core_key_load, core_key, core_din, core_dec, core_abort
   );

   modport master (
      output req_valid, req_key, req_data, req_dec, rsp_ready, core_done, core_dout,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             core_start, core_key_load, core_key, core_din, core_dec, core_abort
   );

endinterface

// File: rtl/crypto_core_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter
   import crypto_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last_grant,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] w_cand;
   logic          w_found;

   // Offset 1..N from the previous winner, so the last winner is checked last.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int i = 1; i <= N; i++) begin
         w_cand = IW'((int'(i_last_grant) + i) % N);
         if (!w_found && i_req[w_cand]) begin
            w_found         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/crypto_core_arbiter.sv
// Shares one start/done block-cipher core between NUM_REQ requesters with
// round-robin grant, key-expansion caching and a watchdog on the core.
module crypto_core_arbiter
   import crypto_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BLOCK_W = 128,
   parameter int KEY_W   = 128,
   parameter int TIMEOUT = 1024
) (
   input logic                clk,
   input logic                rst_n,
   crypto_core_arbiter_if.slave bus
);

   localparam int ID_W = idx_w(NUM_REQ);
   localparam int WD_W = idx_w(TIMEOUT);

   arb_state_e         r_state;
   arb_state_e         w_state_next;

   logic [ID_W-1:0]    r_last_grant;
   logic [ID_W-1:0]    r_grant_idx;
   logic [ID_W-1:0]    w_grant_idx;
   logic [NUM_REQ-1:0] w_grant_oh;

   logic [KEY_W-1:0]   r_key;
   logic [KEY_W-1:0]   r_cached_key;
   logic               r_cached_valid;
   logic [BLOCK_W-1:0] r_din;
   logic               r_dec;
   logic [WD_W-1:0]    r_wdog;

   logic               r_core_start;
   logic               r_core_key_load;
   logic               r_core_abort;
   logic               r_rsp_valid;
   logic [ID_W-1:0]    r_rsp_id;
   logic [BLOCK_W-1:0] r_rsp_data;
   logic               r_rsp_err;

   logic               w_accept;
   logic               w_done_hit;
   logic               w_timeout;
   logic               w_rsp_fire;
   logic               w_key_load;
   logic [KEY_W-1:0]   w_sel_key;

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
      .i_req        (bus.req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant_oh),
      .o_idx        (w_grant_idx)
   );

   assign w_sel_key  = bus.req_key[w_grant_idx];
   assign w_key_load = !r_cached_valid || (w_sel_key != r_cached_key);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // A core_done in the final watchdog cycle takes priority over the abort.
   always_comb begin
      w_state_next  = r_state;
      bus.req_ready = '0;
      w_accept      = 1'b0;
      w_done_hit    = 1'b0;
      w_timeout     = 1'b0;
      w_rsp_fire    = 1'b0;
      case (r_state)
         IDLE: begin
            if (|bus.req_valid) begin
               bus.req_ready = w_grant_oh;
               w_accept      = 1'b1;
               w_state_next  = ISSUE;
            end
         end
         ISSUE: w_state_next = WAIT;
         WAIT: begin
            if (bus.core_done) begin
               w_done_hit   = 1'b1;
               w_state_next = RESP;
            end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_fire   = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // The key compare happens at accept so core_key_load is registered alongside core_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant    <= ID_W'(NUM_REQ - 1);
         r_grant_idx     <= '0;
         r_key           <= '0;
         r_cached_key    <= '0;
         r_cached_valid  <= 1'b0;
         r_din           <= '0;
         r_dec           <= 1'b0;
         r_wdog          <= '0;
         r_core_start    <= 1'b0;
         r_core_key_load <= 1'b0;
         r_core_abort    <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_id        <= '0;
         r_rsp_data      <= '0;
         r_rsp_err       <= 1'b0;
      end else begin
         r_core_start    <= 1'b0;
         r_core_key_load <= 1'b0;
         r_core_abort    <= 1'b0;
         if (w_accept) begin
            r_key           <= w_sel_key;
            r_din           <= bus.req_data[w_grant_idx];
            r_dec           <= bus.req_dec[w_grant_idx];
            r_grant_idx     <= w_grant_idx;
            r_core_start    <= 1'b1;
            r_core_key_load <= w_key_load;
            if (w_key_load) begin
               r_cached_key   <= w_sel_key;
               r_cached_valid <= 1'b1;
            end
         end
         if (r_state == ISSUE)     r_wdog <= '0;
         else if (r_state == WAIT) r_wdog <= r_wdog + 1'b1;
         if (w_done_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_grant_idx;
            r_rsp_data  <= bus.core_dout;
            r_rsp_err   <= 1'b0;
         end
         // An aborted core may have lost its expanded key, so force a reload next time.
         if (w_timeout) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= r_grant_idx;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b1;
            r_core_abort   <= 1'b1;
            r_cached_valid <= 1'b0;
         end
         if (w_rsp_fire) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_grant_idx;
         end
      end
   end

   assign bus.core_start    = r_core_start;
   assign bus.core_key_load = r_core_key_load;
   assign bus.core_key      = r_key;
   assign bus.core_din      = r_din;
   assign bus.core_dec      = r_dec;
   assign bus.core_abort    = r_core_abort;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_id        = r_rsp_id;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_crypto_core_arbiter.sv
// Directed bench for crypto_core_arbiter with a behavioural cipher core that
// honours core_key_load, so a wrongly skipped key expansion corrupts the result.
module tb_crypto_core_arbiter;

   localparam int NUM_REQ = 4;
   localparam int BLOCK_W = 128;
   localparam int KEY_W   = 128;
   localparam int TIMEOUT = 16;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk;
   logic rst_n;

   int vectorsApplied = 0;
   int miscompares    = 0;

   int coreLatency = 10;
   bit coreHang    = 1'b0;
   bit injectDone  = 1'b0;

   crypto_core_arbiter_if #(.NUM_REQ(NUM_REQ), .BLOCK_W(BLOCK_W), .KEY_W(KEY_W)) bus ();

   crypto_core_arbiter #(
      .NUM_REQ (NUM_REQ),
      .BLOCK_W (BLOCK_W),
      .KEY_W   (KEY_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in cipher: the FIPS-197 vector is exact, anything else uses a simple reversible mix.
   function automatic logic [127:0] cipherModel(input logic [127:0] k, input logic [127:0] d, input logic dec);
      if (k == FIPS_KEY && d == FIPS_PT && !dec) return FIPS_CT;
      return {d[63:0], d[127:64]} ^ k ^ {16{8'hA5}} ^ {128{dec}};
   endfunction

   logic [KEY_W-1:0]   modelKey;
   logic               modelKeyValid;
   logic               modelBusy;
   int                 modelCnt;
   logic [BLOCK_W-1:0] modelDin;
   logic               modelDec;

   // Core model: done arrives coreLatency cycles after the start pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.core_done <= 1'b0;
         bus.core_dout <= '0;
         modelBusy     <= 1'b0;
         modelCnt      <= 0;
         modelKeyValid <= 1'b0;
         modelKey      <= '0;
         modelDin      <= '0;
         modelDec      <= 1'b0;
      end else begin
         bus.core_done <= injectDone;
         if (bus.core_abort) begin
            modelBusy     <= 1'b0;
            modelKeyValid <= 1'b0;
         end else if (bus.core_start) begin
            modelBusy <= 1'b1;
            modelCnt  <= 1;
            modelDin  <= bus.core_din;
            modelDec  <= bus.core_dec;
            if (bus.core_key_load) begin
               modelKey      <= bus.core_key;
               modelKeyValid <= 1'b1;
            end
         end else if (modelBusy) begin
            modelCnt <= modelCnt + 1;
            if (!coreHang && modelCnt == coreLatency - 1) begin
               bus.core_done <= 1'b1;
               bus.core_dout <= modelKeyValid ? cipherModel(modelKey, modelDin, modelDec) : {BLOCK_W{1'b1}};
               modelBusy     <= 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int who, input logic [127:0] key, input logic [127:0] data, input logic dec);
      bus.req_key[who]   = key;
      bus.req_data[who]  = data;
      bus.req_dec[who]   = dec;
      bus.req_valid[who] = 1'b1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".ctrl"},
                  {bus.core_start, bus.core_key_load, bus.core_abort, bus.core_dec,
                   bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.req_ready}, 0);
      checkOutput({tag, ".key"},  bus.core_key, 0);
      checkOutput({tag, ".din"},  bus.core_din, 0);
      checkOutput({tag, ".data"}, bus.rsp_data, 0);
   endtask

   task automatic resetDut(input string tag);
      bus.req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkIdleOutputs({tag, ".inReset"});
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkIdleOutputs({tag, ".afterReset"});
   endtask

   // One full transaction: accept, issue, wait for the result, optional backpressure, handshake.
   task automatic serve(input string tag, input int expId, input logic expLoad,
                        input logic [127:0] expData, input logic expErr, input int holdCycles,
                        input bit dropValid, output int latency, output bit abortAtResp);
      int n;
      int gi;
      bit got;
      bit earlyAbort;
      bit busyReady;
      bit stableBad;
      logic [127:0] d0;
      logic [1:0]   id0;
      got = 1'b0; n = 0; gi = 0; latency = 0; abortAtResp = 1'b0;
      earlyAbort = 1'b0; busyReady = 1'b0; stableBad = 1'b0;
      #1;
      while (!got && n < 200) begin
         if (bus.req_ready != '0) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
            n++;
         end
      end
      checkOutput({tag, ".accept"}, got, 1);
      if (!got) return;
      checkOutput({tag, ".oneHot"}, $onehot(bus.req_ready), 1);
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gi = i;
      checkOutput({tag, ".grant"}, gi, expId);
      @(negedge clk);
      #1;
      if (dropValid) bus.req_valid[gi] = 1'b0;
      checkOutput({tag, ".start"}, bus.core_start, 1);
      checkOutput({tag, ".keyLoad"}, bus.core_key_load, expLoad);
      while (!bus.rsp_valid && latency < 2000) begin
         @(negedge clk);
         #1;
         latency++;
         if (bus.core_abort && !bus.rsp_valid) earlyAbort = 1'b1;
         if (bus.req_ready != '0) busyReady = 1'b1;
      end
      abortAtResp = bus.core_abort;
      checkOutput({tag, ".rspValid"}, bus.rsp_valid, 1);
      checkOutput({tag, ".noEarlyAbort"}, earlyAbort, 0);
      d0  = bus.rsp_data;
      id0 = bus.rsp_id;
      for (int c = 0; c < holdCycles; c++) begin
         @(negedge clk);
         #1;
         if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_id !== id0) stableBad = 1'b1;
         if (bus.req_ready != '0) busyReady = 1'b1;
      end
      if (holdCycles > 0) checkOutput({tag, ".holdStable"}, stableBad, 0);
      checkOutput({tag, ".noReadyBusy"}, busyReady, 0);
      checkOutput({tag, ".rspId"}, bus.rsp_id, expId);
      checkOutput({tag, ".rspData"}, bus.rsp_data, expData);
      checkOutput({tag, ".rspErr"}, bus.rsp_err, expErr);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput({tag, ".rspDone"}, bus.rsp_valid, 0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL globalTimeout: observed no finish, expected finish before 400000");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int lat;
      bit ab;
      int n;
      logic [127:0] k;
      logic [127:0] d;
      logic [7:0]   b;
      logic [127:0] keyB;
      logic [127:0] keyC;
      logic [127:0] keyD;

      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_key   = '0;
      bus.req_data  = '0;
      bus.req_dec   = '0;
      bus.rsp_ready = 1'b0;
      keyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      keyC = 128'hffeeddccbbaa99887766554433221100;
      keyD = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

      $display("[TB] reset");
      resetDut("reset");

      $display("[TB] cold key, FIPS-197 vector");
      applyStimulus(0, FIPS_KEY, FIPS_PT, 1'b0);
      serve("cold", 0, 1'b1, FIPS_CT, 1'b0, 0, 1'b1, lat, ab);
      checkOutput("cold.latency", lat, coreLatency + 1);

      $display("[TB] key reuse then key change");
      applyStimulus(0, FIPS_KEY, 128'h0, 1'b0);
      serve("reuse", 0, 1'b0, cipherModel(FIPS_KEY, 128'h0, 1'b0), 1'b0, 0, 1'b1, lat, ab);
      applyStimulus(0, keyB, FIPS_PT, 1'b1);
      serve("newKey", 0, 1'b1, cipherModel(keyB, FIPS_PT, 1'b1), 1'b0, 0, 1'b1, lat, ab);

      $display("[TB] backpressure");
      applyStimulus(1, keyC, 128'h1111, 1'b0);
      applyStimulus(2, keyD, 128'h2222, 1'b1);
      serve("bp", 1, 1'b1, cipherModel(keyC, 128'h1111, 1'b0), 1'b0, 20, 1'b1, lat, ab);
      checkOutput("bp.idleNext", bus.req_ready, 4'b0100);
      serve("bp2", 2, 1'b1, cipherModel(keyD, 128'h2222, 1'b1), 1'b0, 0, 1'b1, lat, ab);

      $display("[TB] watchdog");
      coreHang = 1'b1;
      applyStimulus(2, keyD, 128'h3333, 1'b0);
      serve("wd", 2, 1'b0, 128'h0, 1'b1, 0, 1'b1, lat, ab);
      checkOutput("wd.latency", lat, TIMEOUT + 1);
      checkOutput("wd.abort", ab, 1);
      coreHang = 1'b0;
      applyStimulus(2, keyD, 128'h3333, 1'b0);
      serve("wdNext", 2, 1'b1, cipherModel(keyD, 128'h3333, 1'b0), 1'b0, 0, 1'b1, lat, ab);
      checkOutput("wdNext.noAbort", ab, 0);

      $display("[TB] done on timeout cycle");
      coreLatency = TIMEOUT;
      applyStimulus(2, keyD, 128'h4444, 1'b0);
      serve("tie", 2, 1'b0, cipherModel(keyD, 128'h4444, 1'b0), 1'b0, 0, 1'b1, lat, ab);
      checkOutput("tie.latency", lat, TIMEOUT + 1);
      checkOutput("tie.noAbort", ab, 0);
      coreLatency = 4;

      $display("[TB] round-robin");
      resetDut("rrReset");
      for (int i = 0; i < NUM_REQ; i++) begin
         b = 8'(i + 1);
         k = {16{b}};
         b = 8'(8'h40 + i);
         d = {16{b}};
         applyStimulus(i, k, d, 1'b0);
      end
      for (int t = 0; t < 8; t++) begin
         b = 8'((t % NUM_REQ) + 1);
         k = {16{b}};
         b = 8'(8'h40 + (t % NUM_REQ));
         d = {16{b}};
         serve($sformatf("rr%0d", t), t % NUM_REQ, 1'b1, cipherModel(k, d, 1'b0), 1'b0, 0, 1'b0, lat, ab);
      end
      bus.req_valid = '0;

      $display("[TB] reset during WAIT");
      coreLatency = 10;
      applyStimulus(0, keyB, 128'h5555, 1'b0);
      #1;
      n = 0;
      while (bus.req_ready == '0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("rstWait.accept", bus.req_ready, 4'b0001);
      @(negedge clk);
      #1;
      bus.req_valid = '0;
      checkOutput("rstWait.start", bus.core_start, 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("rstWait.async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      injectDone = 1'b1;
      @(negedge clk);
      #1;
      injectDone = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         checkOutput("rstWait.lateDone", {bus.rsp_valid, bus.core_start, bus.core_abort}, 0);
      end
      for (int i = 0; i < NUM_REQ; i++) bus.req_valid[i] = 1'b1;
      serve("rstWait.first", 0, 1'b1, cipherModel(bus.req_key[0], bus.req_data[0], bus.req_dec[0]),
            1'b0, 0, 1'b0, lat, ab);
      bus.req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
